// File: rtl/grid_renderer.sv
// Tile-grid pixel classifier: two-stage pipeline mapping (x,y) to a cell code or background.
// Define GRID_RENDERER_HIGHLIGHT_EN to flash tiles whose value changed at recent frame starts.

`ifdef GRID_RENDERER_HIGHLIGHT_EN
module grid_flash_cell #(
  parameter int VALUE_W      = 4,
  parameter int FLASH_FRAMES = 8,
  parameter int CNTW         = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_start,
  input  logic [VALUE_W-1:0] cell,
  output logic               active
);
  logic [VALUE_W-1:0] snap;
  logic [CNTW-1:0]    cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      snap <= '0;
      cnt  <= '0;
    end else if (frame_start) begin
      snap <= cell;
      if (cell != snap)    cnt <= CNTW'(FLASH_FRAMES);
      else if (cnt != '0)  cnt <= cnt - 1'b1;
    end
  end

  assign active = (cnt != '0);
endmodule
`endif

module grid_renderer #(
  parameter int GRID_N       = 4,
  parameter int TILE_PX      = 80,
  parameter int GAP_PX       = 10,
  parameter int ORIGIN_PX    = 10,
  parameter int VALUE_W      = 4,
  parameter int BG_CODE      = 12,
  parameter int FLASH_FRAMES = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                pix_valid,
  input  logic [31:0]                         next_x,
  input  logic [31:0]                         next_y,
  input  logic                                frame_start,
  input  logic [GRID_N*GRID_N*VALUE_W-1:0]    cells,
  output logic [VALUE_W-1:0]                  code_out,
  output logic                                code_valid,
  output logic                                hl_out
);
  localparam int PITCH  = TILE_PX + GAP_PX;
  localparam int NCELL  = GRID_N * GRID_N;
  localparam int CW     = (GRID_N > 1) ? $clog2(GRID_N) : 1;
  localparam int IW     = (NCELL > 1) ? $clog2(NCELL) : 1;
  localparam int STAGES = 2;
  localparam logic [VALUE_W-1:0] BG = VALUE_W'(BG_CODE);

  logic [NCELL-1:0][VALUE_W-1:0] cell_arr;
  assign cell_arr = cells;

  function automatic logic [31:0] tile_lo(input int i);
    return 32'(ORIGIN_PX) + 32'(i) * 32'(PITCH);
  endfunction

  function automatic logic [IW-1:0] cell_idx(input logic [CW-1:0] c, input logic [CW-1:0] r);
    return IW'(int'(c) * GRID_N + int'(r));
  endfunction

  // Tiles never overlap, so at most one column/row matches each axis.
  logic          hit_x, hit_y;
  logic [CW-1:0] col, row;
  always_comb begin
    hit_x = 1'b0;
    hit_y = 1'b0;
    col   = '0;
    row   = '0;
    for (int c = 0; c < GRID_N; c++) begin
      if (next_x > tile_lo(c) && next_x < tile_lo(c) + 32'(TILE_PX)) begin
        hit_x = 1'b1;
        col   = CW'(c);
      end
      if (next_y > tile_lo(c) && next_y < tile_lo(c) + 32'(TILE_PX)) begin
        hit_y = 1'b1;
        row   = CW'(c);
      end
    end
  end

  logic hl_s0;
`ifdef GRID_RENDERER_HIGHLIGHT_EN
  localparam int CNTW = $clog2(FLASH_FRAMES + 1);
  logic [NCELL-1:0] flash;
  for (genvar i = 0; i < NCELL; i++) begin : g_cell
    grid_flash_cell #(
      .VALUE_W(VALUE_W), .FLASH_FRAMES(FLASH_FRAMES), .CNTW(CNTW)
    ) u_cell (
      .clk(clk), .rst(rst), .frame_start(frame_start),
      .cell(cell_arr[i]), .active(flash[i])
    );
  end
  assign hl_s0 = hit_x && hit_y && flash[cell_idx(col, row)];
`else
  logic unused_frame_start;
  assign unused_frame_start = frame_start;
  assign hl_s0 = 1'b0;
`endif

  logic [STAGES:1] vld_pipe;
  logic            s1_hit, s1_hl;
  logic [CW-1:0]   s1_col, s1_row;

  // Stage 2 reads the live board, so edits show up one cycle after they land.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      s1_hit   <= 1'b0;
      s1_hl    <= 1'b0;
      s1_col   <= '0;
      s1_row   <= '0;
      code_out <= BG;
      hl_out   <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[1], pix_valid};
      s1_hit   <= hit_x && hit_y;
      s1_hl    <= hl_s0;
      s1_col   <= col;
      s1_row   <= row;
      if (vld_pipe[1]) begin
        code_out <= s1_hit ? cell_arr[cell_idx(s1_col, s1_row)] : BG;
        hl_out   <= s1_hl;
      end
    end
  end

  assign code_valid = vld_pipe[2];
endmodule
